regfile_wb_queue: RTL and testbench

- Writer-side companion to the CPU register file.
- Accepts writeback requests (destination register, 32-bit result) from the execute/memory stages through a valid/ready handshake. Buffers them in a small in-order FIFO and drains at most one per cycle onto the register file's single write port (address, data, write enable).
- Provides combinational bypass lookups so decode-stage reads see results that are still queued or in flight.

---
 rtl/regfile_wb_queue_if.sv | 36 +++
 rtl/regfile_wb_queue.sv | 159 +++++++++++++++
 tb/tb_regfile_wb_queue.sv | 290 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/regfile_wb_queue_if.sv
// rtl/regfile_wb_queue_if.sv - writeback request handshake and register file write port bundle
// Purpose: groups the producer-side request handshake (in_*) and the
//          register file write port (wr_*) of regfile_wb_queue.
// Signals: in_valid/in_ready/in_addr/in_data  writeback request handshake
//          wr_en/wr_addr/wr_data               register file write port
// Modports: master = request producer / write port consumer side
//           slave  = regfile_wb_queue side
interface regfile_wb_queue_if;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  in_addr;
  logic [31:0] in_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  modport master (
    output in_valid,
    output in_addr,
    output in_data,
    input  in_ready,
    input  wr_en,
    input  wr_addr,
    input  wr_data
  );

  modport slave (
    input  in_valid,
    input  in_addr,
    input  in_data,
    output in_ready,
    output wr_en,
    output wr_addr,
    output wr_data
  );
endinterface

// File: rtl/regfile_wb_queue.sv
// rtl/regfile_wb_queue.sv - in-order writeback queue feeding the register file write port
// Purpose: buffers writeback requests in a DEPTH-entry FIFO and drains at most
//          one per cycle into a registered register file write port, with
//          combinational bypass lookups over everything still pending.
// Ports:   clk, rst_n (async, active-low)
//          wb        regfile_wb_queue_if.slave: in_valid/in_ready/in_addr/in_data,
//                    wr_en/wr_addr/wr_data (registered)
//          drain_en  permits a pop this cycle
//          flush     synchronous discard of queued and in-flight writes
//          count     entries queued (output register excluded)
//          byp_addr1/2 -> byp_hit1/2, byp_data1/2 bypass lookups
// Option:  WB_QUEUE_BYPASS_EN builds the bypass comparators; when undefined
//          byp_hit* and byp_data* are tied to 0.
module regfile_wb_queue #(
  parameter int DEPTH = 4,
  parameter int AW    = 2
) (
  input  logic               clk,
  input  logic               rst_n,
  regfile_wb_queue_if.slave  wb,
  input  logic               drain_en,
  input  logic               flush,
  output logic [AW:0]        count,
  input  logic [4:0]         byp_addr1,
  input  logic [4:0]         byp_addr2,
  output logic               byp_hit1,
  output logic [31:0]        byp_data1,
  output logic               byp_hit2,
  output logic [31:0]        byp_data2
);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

  logic [AW-1:0]    head_q, head_d;
  logic [AW-1:0]    tail_q, tail_d;
  logic [AW:0]      count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  logic [4:0]       ent_addr_q [DEPTH];
  logic [4:0]       ent_addr_d [DEPTH];
  logic [31:0]      ent_data_q [DEPTH];
  logic [31:0]      ent_data_d [DEPTH];
  logic             wr_en_q, wr_en_d;
  logic [4:0]       wr_addr_q, wr_addr_d;
  logic [31:0]      wr_data_q, wr_data_d;
  logic             in_ready;
  logic             push;
  logic             pop;

  // Readiness depends only on occupancy: a pop in the same cycle does not
  // free a slot for the incoming request.
  assign in_ready = (count_q != FULL_CNT);
  // Register 0 requests complete the handshake but are never stored.
  assign push     = wb.in_valid && in_ready && !flush && (wb.in_addr != 5'd0);
  assign pop      = (count_q != '0) && drain_en && !flush;

  always_comb begin
    head_d     = head_q;
    tail_d     = tail_q;
    count_d    = count_q;
    valid_d    = valid_q;
    ent_addr_d = ent_addr_q;
    ent_data_d = ent_data_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    if (flush) begin
      head_d  = '0;
      tail_d  = '0;
      count_d = '0;
      valid_d = '0;
    end else begin
      if (pop) begin
        wr_en_d         = 1'b1;
        wr_addr_d       = ent_addr_q[head_q];
        wr_data_d       = ent_data_q[head_q];
        valid_d[head_q] = 1'b0;
        head_d          = head_q + 1'b1;
      end
      // Full queues never push, so tail and head cannot collide here.
      if (push) begin
        ent_addr_d[tail_q] = wb.in_addr;
        ent_data_d[tail_q] = wb.in_data;
        valid_d[tail_q]    = 1'b1;
        tail_d             = tail_q + 1'b1;
      end
      count_d = count_q + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      head_q    <= '0;
      tail_q    <= '0;
      count_q   <= '0;
      valid_q   <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ent_addr_q[i] <= '0;
        ent_data_q[i] <= '0;
      end
    end else begin
      head_q     <= head_d;
      tail_q     <= tail_d;
      count_q    <= count_d;
      valid_q    <= valid_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      ent_addr_q <= ent_addr_d;
      ent_data_q <= ent_data_d;
    end
  end

  assign wb.in_ready = in_ready;
  assign wb.wr_en    = wr_en_q;
  assign wb.wr_addr  = wr_addr_q;
  assign wb.wr_data  = wr_data_q;
  assign count       = count_q;

`ifdef WB_QUEUE_BYPASS_EN
  // Candidates are scanned oldest to youngest so the last match wins:
  // output register first, then queue entries from head towards tail-1.
  always_comb begin : byp_lookup
    logic [AW-1:0] idx;
    byp_hit1  = 1'b0;
    byp_data1 = '0;
    byp_hit2  = 1'b0;
    byp_data2 = '0;
    idx       = head_q;
    if (wr_en_q && (byp_addr1 != 5'd0) && (wr_addr_q == byp_addr1)) begin
      byp_hit1  = 1'b1;
      byp_data1 = wr_data_q;
    end
    if (wr_en_q && (byp_addr2 != 5'd0) && (wr_addr_q == byp_addr2)) begin
      byp_hit2  = 1'b1;
      byp_data2 = wr_data_q;
    end
    for (int i = 0; i < DEPTH; i++) begin
      idx = head_q + AW'(i);
      if (valid_q[idx] && (byp_addr1 != 5'd0) && (ent_addr_q[idx] == byp_addr1)) begin
        byp_hit1  = 1'b1;
        byp_data1 = ent_data_q[idx];
      end
      if (valid_q[idx] && (byp_addr2 != 5'd0) && (ent_addr_q[idx] == byp_addr2)) begin
        byp_hit2  = 1'b1;
        byp_data2 = ent_data_q[idx];
      end
    end
  end
`else
  logic byp_unused;
  assign byp_unused = ^{byp_addr1, byp_addr2};
  assign byp_hit1   = 1'b0;
  assign byp_data1  = '0;
  assign byp_hit2   = 1'b0;
  assign byp_data2  = '0;
`endif
endmodule

// File: tb/tb_regfile_wb_queue.sv
// tb/tb_regfile_wb_queue.sv - directed self-checking bench for regfile_wb_queue
module tb_regfile_wb_queue;
  localparam int DEPTH = 4;
  localparam int AW    = 2;
`ifdef WB_QUEUE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    logic [4:0]  addr;
    logic [31:0] data;
  } ent_t;

  logic        clk;
  logic        rst_n;
  logic        drain_en;
  logic        flush;
  logic [AW:0] count;
  logic [4:0]  byp_addr1;
  logic [4:0]  byp_addr2;
  logic        byp_hit1;
  logic [31:0] byp_data1;
  logic        byp_hit2;
  logic [31:0] byp_data2;

  regfile_wb_queue_if wb ();

  regfile_wb_queue #(.DEPTH(DEPTH), .AW(AW)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .wb        (wb),
    .drain_en  (drain_en),
    .flush     (flush),
    .count     (count),
    .byp_addr1 (byp_addr1),
    .byp_addr2 (byp_addr2),
    .byp_hit1  (byp_hit1),
    .byp_data1 (byp_data1),
    .byp_hit2  (byp_hit2),
    .byp_data2 (byp_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model state: pending writes oldest-first plus the write-port register.
  ent_t        mq[$];
  logic        m_wr_en   = 1'b0;
  logic [4:0]  m_wr_addr = '0;
  logic [31:0] m_wr_data = '0;

  int total = 0;
  int bad   = 0;

  function automatic void chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endfunction

  function automatic void model_clear();
    mq.delete();
    m_wr_en   = 1'b0;
    m_wr_addr = '0;
    m_wr_data = '0;
  endfunction

  // Youngest pending write for a register, searching the queue from its
  // newest element back, then the write-port register.
  function automatic void exp_byp(input logic [4:0] a, output logic hit, output logic [31:0] d);
    hit = 1'b0;
    d   = '0;
    if (BYP && a != 5'd0) begin
      for (int i = mq.size() - 1; i >= 0; i--) begin
        if (!hit && mq[i].addr == a) begin
          hit = 1'b1;
          d   = mq[i].data;
        end
      end
      if (!hit && m_wr_en && m_wr_addr == a) begin
        hit = 1'b1;
        d   = m_wr_data;
      end
    end
  endfunction

  always @(negedge clk) begin
    logic        h1, h2;
    logic [31:0] d1, d2;
    exp_byp(byp_addr1, h1, d1);
    exp_byp(byp_addr2, h2, d2);
    chk("cmp_count", 32'(count), 32'(mq.size()));
    chk("cmp_in_ready", 32'(wb.in_ready), 32'(mq.size() < DEPTH));
    chk("cmp_wr_en", 32'(wb.wr_en), 32'(m_wr_en));
    chk("cmp_wr_addr", 32'(wb.wr_addr), 32'(m_wr_addr));
    chk("cmp_wr_data", wb.wr_data, m_wr_data);
    chk("cmp_byp_hit1", 32'(byp_hit1), 32'(h1));
    chk("cmp_byp_data1", byp_data1, d1);
    chk("cmp_byp_hit2", 32'(byp_hit2), 32'(h2));
    chk("cmp_byp_data2", byp_data2, d2);
  end

  // One clock edge: the model decides push/pop from the inputs held stable
  // across the edge, then control returns just after the next falling edge.
  task automatic tick();
    logic push, pop;
    ent_t e;
    push   = wb.in_valid && (mq.size() < DEPTH) && !flush && (wb.in_addr != 5'd0);
    pop    = (mq.size() > 0) && drain_en && !flush;
    e.addr = wb.in_addr;
    e.data = wb.in_data;
    @(posedge clk);
    if (!rst_n) begin
      model_clear();
    end else if (flush) begin
      mq.delete();
      m_wr_en = 1'b0;
    end else begin
      if (pop) begin
        m_wr_en   = 1'b1;
        m_wr_addr = mq[0].addr;
        m_wr_data = mq[0].data;
        mq.delete(0);
      end else begin
        m_wr_en = 1'b0;
      end
      if (push) mq.push_back(e);
    end
    @(negedge clk);
    #1;
  endtask

  task automatic req(input logic v, input logic [4:0] a, input logic [31:0] d);
    wb.in_valid = v;
    wb.in_addr  = a;
    wb.in_data  = d;
  endtask

  initial begin
    rst_n     = 1'b0;
    drain_en  = 1'b0;
    flush     = 1'b0;
    byp_addr1 = '0;
    byp_addr2 = '0;
    req(1'b0, 5'd0, 32'd0);
    model_clear();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_wr_en", 32'(wb.wr_en), 32'd0);
    chk("rst_wr_addr", 32'(wb.wr_addr), 32'd0);
    chk("rst_wr_data", wb.wr_data, 32'd0);
    chk("rst_in_ready", 32'(wb.in_ready), 32'd1);
    rst_n = 1'b1;
    tick();

    // Single write: latency through queue and write port.
    drain_en = 1'b1;
    req(1'b1, 5'd5, 32'h0000_00AA);
    tick();
    chk("t1_count_e1", 32'(count), 32'd1);
    chk("t1_wr_en_e1", 32'(wb.wr_en), 32'd0);
    req(1'b0, 5'd0, 32'd0);
    tick();
    chk("t1_wr_en_e2", 32'(wb.wr_en), 32'd1);
    chk("t1_wr_addr_e2", 32'(wb.wr_addr), 32'd5);
    chk("t1_wr_data_e2", wb.wr_data, 32'h0000_00AA);
    tick();
    chk("t1_wr_en_e3", 32'(wb.wr_en), 32'd0);

    // Fill to DEPTH, refuse extra pushes, drain in order.
    drain_en = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      req(1'b1, 5'(k), 32'(k * 32'h11));
      tick();
    end
    chk("t2_count_full", 32'(count), 32'd4);
    chk("t2_in_ready_full", 32'(wb.in_ready), 32'd0);
    req(1'b1, 5'd6, 32'h66);
    tick();
    chk("t2_count_refused", 32'(count), 32'd4);
    drain_en = 1'b1;
    tick();
    chk("t2_no_passthru", 32'(count), 32'd3);
    chk("t2_wr_addr_1", 32'(wb.wr_addr), 32'd1);
    chk("t2_wr_data_1", wb.wr_data, 32'h11);
    req(1'b0, 5'd0, 32'd0);
    for (int k = 2; k <= 4; k++) begin
      tick();
      chk("t2_wr_en_seq", 32'(wb.wr_en), 32'd1);
      chk("t2_wr_addr_seq", 32'(wb.wr_addr), 32'(k));
      chk("t2_wr_data_seq", wb.wr_data, 32'(k * 32'h11));
    end
    tick();
    chk("t2_drained", 32'(wb.wr_en), 32'd0);

    // Two writes to one register: bypass returns the younger.
    drain_en = 1'b0;
    req(1'b1, 5'd7, 32'h10);
    tick();
    req(1'b1, 5'd7, 32'h20);
    tick();
    req(1'b0, 5'd0, 32'd0);
    byp_addr1 = 5'd7;
    byp_addr2 = 5'd8;
    #1;
    chk("t3_hit1", 32'(byp_hit1), 32'(BYP));
    chk("t3_data1", byp_data1, BYP ? 32'h20 : 32'h0);
    chk("t3_hit2", 32'(byp_hit2), 32'd0);
    chk("t3_data2", byp_data2, 32'd0);
    drain_en = 1'b1;
    tick();
    chk("t3_order_first", wb.wr_data, 32'h10);
    chk("t3_data1_q", byp_data1, BYP ? 32'h20 : 32'h0);
    tick();
    chk("t3_order_second", wb.wr_data, 32'h20);
    chk("t3_data1_outreg", byp_data1, BYP ? 32'h20 : 32'h0);
    tick();
    chk("t3_hit1_gone", 32'(byp_hit1), 32'd0);

    // Register 0 request is accepted but discarded.
    byp_addr1 = 5'd0;
    req(1'b1, 5'd0, 32'hFFFF_FFFF);
    #1;
    chk("t4_in_ready", 32'(wb.in_ready), 32'd1);
    tick();
    req(1'b0, 5'd0, 32'd0);
    chk("t4_count", 32'(count), 32'd0);
    chk("t4_hit1", 32'(byp_hit1), 32'd0);
    tick();
    chk("t4_wr_en", 32'(wb.wr_en), 32'd0);

    // Flush with a concurrent push and with an in-flight write.
    drain_en  = 1'b0;
    byp_addr1 = 5'd10;
    byp_addr2 = 5'd9;
    for (int k = 10; k <= 12; k++) begin
      req(1'b1, 5'(k), 32'(k + 32'h100));
      tick();
    end
    drain_en = 1'b1;
    req(1'b0, 5'd0, 32'd0);
    tick();
    chk("t5_pre_wr_en", 32'(wb.wr_en), 32'd1);
    req(1'b1, 5'd9, 32'h999);
    flush = 1'b1;
    tick();
    flush = 1'b0;
    req(1'b0, 5'd0, 32'd0);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_wr_en", 32'(wb.wr_en), 32'd0);
    chk("t5_hit1", 32'(byp_hit1), 32'd0);
    chk("t5_hit2", 32'(byp_hit2), 32'd0);
    repeat (3) begin
      tick();
      chk("t5_no_stale", 32'(wb.wr_en), 32'd0);
    end

    // Asynchronous reset while a write is in flight.
    drain_en = 1'b0;
    req(1'b1, 5'd13, 32'hD);
    tick();
    req(1'b1, 5'd14, 32'hE);
    tick();
    req(1'b0, 5'd0, 32'd0);
    drain_en = 1'b1;
    tick();
    chk("t6_pre_wr_en", 32'(wb.wr_en), 32'd1);
    chk("t6_pre_count", 32'(count), 32'd1);
    #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("t6_async_wr_en", 32'(wb.wr_en), 32'd0);
    chk("t6_async_count", 32'(count), 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (3) begin
      tick();
      chk("t6_no_stale", 32'(wb.wr_en), 32'd0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
